// File: rtl/div_u27_u21_arbiter.sv
// rtl/div_u27_u21_arbiter.sv - round-robin share of one pipelined u27/u21 divider among N_REQ requesters
// Optional divide-by-zero flagging is built when DIV_ZERO_CHECK_EN is defined.
module div_u27_u21_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DIV_LAT = 4,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [27*N_REQ-1:0] req_dividend_i,
  input  logic [21*N_REQ-1:0] req_divisor_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic                div_clken_o,
  output logic [26:0]         div_dividend_o,
  output logic [20:0]         div_divisor_o,
  input  logic [26:0]         div_quotient_i,
  input  logic [20:0]         div_remain_i,
  output logic                rsp_valid_o,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [26:0]         rsp_quotient_o,
  output logic [20:0]         rsp_remain_o,
  output logic                rsp_dz_o,
  output logic                busy_o
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [DIV_LAT:0] vld_q;
  logic [ID_W-1:0]  tag_q [0:DIV_LAT];
  logic [26:0]      dvd_q;
  logic [20:0]      dvs_q;

  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [26:0]      rsp_quo_q, rsp_quo_d;
  logic [20:0]      rsp_rem_q, rsp_rem_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;
  logic [N_REQ-1:0] gnt_vec;
  logic [26:0]      sel_dividend;
  logic [20:0]      sel_divisor;
  logic [ID_W:0]    sum;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      if (!gnt_any && req_valid_i[sum[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[ID_W-1:0];
      end
    end
    if (stall_i || !rst_n) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    gnt_vec      = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_any && (gnt_idx == ID_W'(i))) begin
        gnt_vec[i]   = 1'b1;
        sel_dividend = req_dividend_i[27*i +: 27];
        sel_divisor  = req_divisor_i[21*i +: 21];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      vld_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      for (int k = 0; k <= DIV_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else if (!stall_i) begin
      ptr_q <= ptr_d;
      vld_q <= {vld_q[DIV_LAT-1:0], gnt_any};
      tag_q[0] <= gnt_idx;
      for (int k = 1; k <= DIV_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (gnt_any) begin
        dvd_q <= sel_dividend;
        dvs_q <= sel_divisor;
      end
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  logic [DIV_LAT:0] dz_q;
  logic [20:0]      low_q [0:DIV_LAT];

  // Zero divisors still occupy a divider slot; the low dividend bits ride along as the remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= '0;
      for (int k = 0; k <= DIV_LAT; k++) begin
        low_q[k] <= '0;
      end
    end else if (!stall_i) begin
      dz_q     <= {dz_q[DIV_LAT-1:0], gnt_any && (sel_divisor == 21'd0)};
      low_q[0] <= sel_dividend[20:0];
      for (int k = 1; k <= DIV_LAT; k++) begin
        low_q[k] <= low_q[k-1];
      end
    end
  end

  always_comb begin
    rsp_quo_d = div_quotient_i;
    rsp_rem_d = div_remain_i;
    rsp_dz_d  = 1'b0;
    if (dz_q[DIV_LAT]) begin
      rsp_quo_d = 27'h7FFFFFF;
      rsp_rem_d = low_q[DIV_LAT];
      rsp_dz_d  = 1'b1;
    end
  end
`else
  always_comb begin
    rsp_quo_d = div_quotient_i;
    rsp_rem_d = div_remain_i;
    rsp_dz_d  = 1'b0;
  end
`endif

  // A strobe pending under stall is held and shown once on the first unstalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else if (!stall_i) begin
      rsp_valid_q <= vld_q[DIV_LAT];
      if (vld_q[DIV_LAT]) begin
        rsp_id_q  <= tag_q[DIV_LAT];
        rsp_quo_q <= rsp_quo_d;
        rsp_rem_q <= rsp_rem_d;
        rsp_dz_q  <= rsp_dz_d;
      end
    end
  end

  assign req_ready_o    = gnt_vec;
  assign div_clken_o    = !stall_i && (|vld_q[DIV_LAT-1:0]);
  assign div_dividend_o = dvd_q;
  assign div_divisor_o  = dvs_q;
  assign rsp_valid_o    = rsp_valid_q && !stall_i;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_quotient_o = rsp_quo_q;
  assign rsp_remain_o   = rsp_rem_q;
  assign rsp_dz_o       = rsp_dz_q;
  assign busy_o         = (|vld_q) || rsp_valid_o;

endmodule

// File: tb/tb_div_u27_u21_arbiter.sv
// tb/tb_div_u27_u21_arbiter.sv - directed self-checking bench for div_u27_u21_arbiter
module tb_div_u27_u21_arbiter;
  localparam int N = 4;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall_i = 1'b0;
  logic [3:0]   req_valid_i = '0;
  logic [107:0] req_dividend_i = '0;
  logic [83:0]  req_divisor_i = '0;
  logic [3:0]   req_ready_o;
  logic         div_clken_o;
  logic [26:0]  div_dividend_o;
  logic [20:0]  div_divisor_o;
  logic [26:0]  div_quotient_i;
  logic [20:0]  div_remain_i;
  logic         rsp_valid_o;
  logic [1:0]   rsp_id_o;
  logic [26:0]  rsp_quotient_o;
  logic [20:0]  rsp_remain_o;
  logic         rsp_dz_o;
  logic         busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  div_u27_u21_arbiter #(.N_REQ(N), .DIV_LAT(L), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .req_valid_i(req_valid_i), .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .req_ready_o(req_ready_o), .div_clken_o(div_clken_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_quotient_i(div_quotient_i), .div_remain_i(div_remain_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_quotient_o(rsp_quotient_o),
    .rsp_remain_o(rsp_remain_o), .rsp_dz_o(rsp_dz_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: L clken-gated stages after the operand sample.
  logic [26:0] mq [0:L-1];
  logic [20:0] mr [0:L-1];
  initial begin
    for (int k = 0; k < L; k++) begin
      mq[k] = '0;
      mr[k] = '0;
    end
  end
  always @(posedge clk) begin
    if (div_clken_o) begin
      if (div_divisor_o == 21'd0) begin
        mq[0] <= '0;
        mr[0] <= '0;
      end else begin
        mq[0] <= div_dividend_o / {6'd0, div_divisor_o};
        mr[0] <= 21'(div_dividend_o % {6'd0, div_divisor_o});
      end
      for (int k = 1; k < L; k++) begin
        mq[k] <= mq[k-1];
        mr[k] <= mr[k-1];
      end
    end
  end
  assign div_quotient_i = mq[L-1];
  assign div_remain_i   = mr[L-1];

  int          mon_id [$];
  int          mon_q  [$];
  int          mon_r  [$];
  int          mon_cyc[$];
  always @(negedge clk) begin
    if (rsp_valid_o) begin
      mon_id.push_back(int'(rsp_id_o));
      mon_q.push_back(int'(rsp_quotient_o));
      mon_r.push_back(int'(rsp_remain_o));
      mon_cyc.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int dvd, input int dvs);
    req_dividend_i[27*i +: 27] = 27'(dvd);
    req_divisor_i[21*i +: 21]  = 21'(dvs);
  endtask

  task automatic apply_reset;
    req_valid_i = '0;
    stall_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mon_id.delete(); mon_q.delete(); mon_r.delete(); mon_cyc.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid_i = 4'b1111;
    tick();
    tick();
    total_cnt++; if (req_ready_o !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready_o); else pass_cnt++;
    total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
    total_cnt++; if (div_clken_o !== 1'b0) $display("FAIL reset_clken: got %b expected 0", div_clken_o); else pass_cnt++;
    total_cnt++; if ({div_dividend_o, div_divisor_o, rsp_quotient_o, rsp_remain_o, rsp_id_o, rsp_dz_o} !== '0)
      $display("FAIL reset_data: got nonzero data outputs expected all 0"); else pass_cnt++;
    req_valid_i = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    apply_reset();
    set_req(2, 100, 7);
    req_valid_i = 4'b0100;
    #1;
    total_cnt++; if (req_ready_o !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", req_ready_o); else pass_cnt++;
    tick();
    req_valid_i = '0;
    for (int k = 1; k <= 8; k++) begin
      total_cnt++; if (div_clken_o !== (k <= 4)) $display("FAIL single_clken_T%0d: got %b expected %b", k, div_clken_o, (k <= 4)); else pass_cnt++;
      total_cnt++; if (rsp_valid_o !== (k == 6)) $display("FAIL single_rsp_valid_T%0d: got %b expected %b", k, rsp_valid_o, (k == 6)); else pass_cnt++;
      if (k == 6) begin
        total_cnt++; if (rsp_id_o !== 2'd2) $display("FAIL single_id: got %0d expected 2", rsp_id_o); else pass_cnt++;
        total_cnt++; if (rsp_quotient_o !== 27'd14) $display("FAIL single_q: got %0d expected 14", rsp_quotient_o); else pass_cnt++;
        total_cnt++; if (rsp_remain_o !== 21'd2) $display("FAIL single_r: got %0d expected 2", rsp_remain_o); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_contention;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int exp_q  [4] = '{335, 501, 601, 667};
    int exp_r  [4] = '{2, 3, 2, 5};
    int t0;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1000 * (i + 1) + 7, i + 3);
    req_valid_i = 4'b1111;
    #1;
    t0 = cyc;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (req_ready_o !== 4'(1 << exp_id[c])) $display("FAIL contention_grant%0d: got %b expected %b", c, req_ready_o, 4'(1 << exp_id[c])); else pass_cnt++;
      tick();
    end
    req_valid_i = '0;
    repeat (10) tick();
    total_cnt++; if (mon_id.size() != 5) $display("FAIL contention_count: got %0d expected 5", mon_id.size()); else pass_cnt++;
    for (int j = 0; j < 5 && j < mon_id.size(); j++) begin
      total_cnt++; if (mon_id[j] != exp_id[j]) $display("FAIL contention_id%0d: got %0d expected %0d", j, mon_id[j], exp_id[j]); else pass_cnt++;
      total_cnt++; if (mon_q[j] != exp_q[exp_id[j]] || mon_r[j] != exp_r[exp_id[j]])
        $display("FAIL contention_data%0d: got %0d r %0d expected %0d r %0d", j, mon_q[j], mon_r[j], exp_q[exp_id[j]], exp_r[exp_id[j]]); else pass_cnt++;
      total_cnt++; if (mon_cyc[j] != t0 + 6 + j) $display("FAIL contention_cycle%0d: got %0d expected %0d", j, mon_cyc[j], t0 + 6 + j); else pass_cnt++;
    end
  endtask

  task automatic test_fairness;
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 77, 5);
    req_valid_i = 4'b1010;
    #1;
    for (int c = 0; c < 6; c++) begin
      exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      total_cnt++; if (req_ready_o !== exp) $display("FAIL fairness_grant%0d: got %b expected %b", c, req_ready_o, exp); else pass_cnt++;
      tick();
    end
    req_valid_i = '0;
    repeat (10) tick();
    total_cnt++; if (mon_id.size() != 6) $display("FAIL fairness_count: got %0d expected 6", mon_id.size()); else pass_cnt++;
  endtask

  task automatic test_stall;
    apply_reset();
    set_req(0, 134217727, 1);
    req_valid_i = 4'b0001;
    #1;
    tick();
    req_valid_i = '0;
    for (int k = 1; k <= 12; k++) begin
      stall_i = (k <= 3);
      #1;
      if (k == 2) begin
        req_valid_i = 4'b0010;
        #1;
        total_cnt++; if (req_ready_o !== 4'b0000) $display("FAIL stall_ready: got %b expected 0000", req_ready_o); else pass_cnt++;
        total_cnt++; if (div_clken_o !== 1'b0) $display("FAIL stall_clken: got %b expected 0", div_clken_o); else pass_cnt++;
        req_valid_i = '0;
      end
      total_cnt++; if (rsp_valid_o !== (k == 9)) $display("FAIL stall_rsp_valid_T%0d: got %b expected %b", k, rsp_valid_o, (k == 9)); else pass_cnt++;
      if (k == 9) begin
        total_cnt++; if (rsp_quotient_o !== 27'd134217727) $display("FAIL stall_q: got %0d expected 134217727", rsp_quotient_o); else pass_cnt++;
        total_cnt++; if (rsp_remain_o !== 21'd0) $display("FAIL stall_r: got %0d expected 0", rsp_remain_o); else pass_cnt++;
      end
      tick();
    end
    stall_i = 1'b0;
  endtask

  task automatic test_div_zero;
    apply_reset();
    set_req(1, 500, 0);
    req_valid_i = 4'b0010;
    #1;
    tick();
    req_valid_i = '0;
    repeat (5) tick();
    total_cnt++; if (rsp_valid_o !== 1'b1) $display("FAIL dz_valid: got %b expected 1", rsp_valid_o); else pass_cnt++;
    total_cnt++; if (rsp_id_o !== 2'd1) $display("FAIL dz_id: got %0d expected 1", rsp_id_o); else pass_cnt++;
`ifdef DIV_ZERO_CHECK_EN
    total_cnt++; if (rsp_dz_o !== 1'b1) $display("FAIL dz_flag: got %b expected 1", rsp_dz_o); else pass_cnt++;
    total_cnt++; if (rsp_quotient_o !== 27'h7FFFFFF) $display("FAIL dz_q: got %h expected 7ffffff", rsp_quotient_o); else pass_cnt++;
    total_cnt++; if (rsp_remain_o !== 21'd500) $display("FAIL dz_r: got %0d expected 500", rsp_remain_o); else pass_cnt++;
`else
    total_cnt++; if (rsp_dz_o !== 1'b0) $display("FAIL dz_flag: got %b expected 0", rsp_dz_o); else pass_cnt++;
`endif
    tick();
  endtask

  task automatic test_reset_mid;
    bit seen;
    apply_reset();
    set_req(1, 70, 7);
    set_req(2, 50, 5);
    set_req(3, 60, 6);
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = 4'b1000;
    tick();
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL midreset_busy_before: got %b expected 1", busy_o); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy_o, div_clken_o, rsp_valid_o} !== 3'b000) $display("FAIL midreset_ctrl: got %b expected 000", {busy_o, div_clken_o, rsp_valid_o}); else pass_cnt++;
    total_cnt++; if ({div_dividend_o, div_divisor_o} !== '0) $display("FAIL midreset_operands: got %0d/%0d expected 0/0", div_dividend_o, div_divisor_o); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid_o) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL midreset_no_rsp: got %b expected 0", seen); else pass_cnt++;
    req_valid_i = 4'b1110;
    #1;
    total_cnt++; if (req_ready_o !== 4'b0010) $display("FAIL midreset_grant: got %b expected 0010", req_ready_o); else pass_cnt++;
    req_valid_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_stall();
    test_div_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
